// File: rtl/sync_ram_fifo.sv
// sync_ram_fifo: single-clock FIFO over an inferred simple dual-port RAM.
// One write port and one registered read port. Pointers wrap modulo DEPTH.
// Occupancy drives the full, empty and almost-full flags. A read is
// qualified by a one-cycle pop_valid_o strobe.
// Optional build macro SYNC_RAM_FIFO_ERROR_FLAGS_EN adds two sticky flags:
// overflow_o (push while full) and underflow_o (pop while empty).
module sync_ram_fifo #(
   parameter int DATA_WIDTH        = 32,
   parameter int DEPTH             = 512,
   parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [DATA_WIDTH-1:0]   push_data_i,
   output logic                    full_o,
   output logic                    almost_full_o,
   input  logic                    pop_i,
   output logic [DATA_WIDTH-1:0]   pop_data_o,
   output logic                    pop_valid_o,
   output logic                    empty_o,
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
   output logic                    overflow_o,
   output logic                    underflow_o,
`endif
   output logic [$clog2(DEPTH):0]  fill_level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
   logic                  pop_valid_q, pop_valid_d;
   logic                  push_acc, pop_acc;

   // Flags come straight from the registered level, so the accept terms
   // below never form a combinational loop.
   assign full_o        = (level_q == DEPTH_L);
   assign empty_o       = (level_q == '0);
   assign almost_full_o = (level_q >= AF_L);
   assign fill_level_o  = level_q;
   assign pop_data_o    = pop_data_q;
   assign pop_valid_o   = pop_valid_q;

   // Accept terms and next-state for pointers, level and read register.
   always_comb begin
      push_acc    = push_i & ~full_o;
      pop_acc     = pop_i & ~empty_o;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = pop_acc;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         pop_data_d = mem_q[rd_ptr_q];
      end
      case ({push_acc, pop_acc})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state and read register. Reset wins over a same-edge pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   // Storage array write port; never reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

   // Error flags latch on any dropped request and hold until reset.
   always_comb begin
      overflow_d  = overflow_q | (push_i & full_o);
      underflow_d = underflow_q | (pop_i & empty_o);
   end

   // Sticky error flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
`endif

endmodule

// File: tb/tb_sync_ram_fifo.sv
// Testbench for sync_ram_fifo with DEPTH=8, DATA_WIDTH=32, ALMOST_FULL_LEVEL=6.
// Each table row is one clock cycle: the inputs applied before the edge and
// the outputs expected just after it.
module tb_sync_ram_fifo;

   logic        clock = 1'b0;
   logic        reset;
   logic        push;
   logic [31:0] push_data;
   logic        pop;
   logic        full, almost_full, empty, pop_valid;
   logic [31:0] pop_data;
   logic [3:0]  fill_level;
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
   logic        overflow, underflow;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   sync_ram_fifo #(
      .DATA_WIDTH(32), .DEPTH(8), .ALMOST_FULL_LEVEL(6)
   ) dut (
      .clock(clock),
      .reset(reset),
      .push_i(push),
      .push_data_i(push_data),
      .full_o(full),
      .almost_full_o(almost_full),
      .pop_i(pop),
      .pop_data_o(pop_data),
      .pop_valid_o(pop_valid),
      .empty_o(empty),
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
      .overflow_o(overflow),
      .underflow_o(underflow),
`endif
      .fill_level_o(fill_level)
   );

   typedef struct {
      logic push;
      int   data;
      logic pop;
      int   lvl;
      logic v;
      int   dat;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic p, input int d, input logic q,
                               input int lvl, input logic v, input int dat);
      vec_t e;
      e.push = p; e.data = d; e.pop = q; e.lvl = lvl; e.v = v; e.dat = dat;
      vq.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_state(input string tag, input int lvl, input logic v, input int dat);
      chk({tag, " level"}, 32'(fill_level), 32'(lvl));
      chk({tag, " full"}, 32'(full), 32'(lvl == 8));
      chk({tag, " empty"}, 32'(empty), 32'(lvl == 0));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(lvl >= 6));
      chk({tag, " pop_valid"}, 32'(pop_valid), 32'(v));
      chk({tag, " pop_data"}, pop_data, 32'(dat));
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
      step();
      step();
      chk_state("reset", 0, 1'b0, 0);
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset underflow", 32'(underflow), 32'd0);
`endif
      reset = 1'b0;

      // pop while empty, then fill past full, drain, wrap, simultaneous cases
      add(0, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) add(1, 'h11 * i, 0, i, 0, 0);
      add(1, 'h99, 0, 8, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 0, 1, 8 - i, 1, 'h11 * i);
      add(0, 0, 0, 0, 0, 'h88);
      for (int i = 1; i <= 5; i++) add(1, 'hA0 + i, 0, i, 0, 'h88);
      for (int i = 1; i <= 5; i++) add(0, 0, 1, 5 - i, 1, 'hA0 + i);
      for (int i = 1; i <= 6; i++) add(1, 'hB0 + i, 0, i, 0, 'hA5);
      for (int i = 1; i <= 6; i++) add(0, 0, 1, 6 - i, 1, 'hB0 + i);
      for (int i = 1; i <= 3; i++) add(1, 'hC0 + i, 0, i, 0, 'hB6);
      add(1, 'hC4, 1, 3, 1, 'hC1);
      add(1, 'hC5, 1, 3, 1, 'hC2);
      for (int i = 3; i <= 5; i++) add(0, 0, 1, 5 - i, 1, 'hC0 + i);
      for (int i = 1; i <= 8; i++) add(1, 'hD0 + i, 0, i, 0, 'hC5);
      add(1, 'hE0, 1, 7, 1, 'hD1);
      for (int i = 2; i <= 8; i++) add(0, 0, 1, 8 - i, 1, 'hD0 + i);
      add(1, 'hF1, 1, 1, 0, 'hD8);
      add(0, 0, 1, 0, 1, 'hF1);

      for (int k = 0; k < vq.size(); k++) begin
         push      = vq[k].push;
         push_data = 32'(vq[k].data);
         pop       = vq[k].pop;
         step();
         chk_state($sformatf("vec%0d", k), vq[k].lvl, vq[k].v, vq[k].dat);
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
         if (k == 0) chk("underflow after empty pop", 32'(underflow), 32'd1);
         if (k == 8) chk("overflow before full push", 32'(overflow), 32'd0);
         if (k == 9) chk("overflow after full push", 32'(overflow), 32'd1);
`endif
      end
      push = 1'b0; pop = 1'b0;

      // reset together with a pop while holding 5 words
      for (int i = 1; i <= 5; i++) begin
         push = 1'b1; push_data = 32'('h50 + i);
         step();
      end
      push = 1'b0;
      chk("pre-reset level", 32'(fill_level), 32'd5);
      reset = 1'b1; pop = 1'b1;
      step();
      reset = 1'b0; pop = 1'b0;
      chk_state("mid reset", 0, 1'b0, 0);
`ifdef SYNC_RAM_FIFO_ERROR_FLAGS_EN
      chk("mid reset overflow", 32'(overflow), 32'd0);
      chk("mid reset underflow", 32'(underflow), 32'd0);
`endif
      push = 1'b1; push_data = 32'hAB;
      step();
      push = 1'b0;
      chk_state("post reset push", 1, 1'b0, 0);
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk_state("post reset pop", 0, 1'b1, 'hAB);
      step();
      chk_state("post reset idle", 0, 1'b0, 'hAB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
